// File: rtl/fpu_div_issue_pkg.sv
// Shared FP types and the issue-adapter FSM state encoding.
package fpu_div_issue_pkg;

    typedef logic [15:0] fp16_t;
    typedef logic [31:0] fp32_t;

    // Opaque condition codes as produced by fpuDiv.
    typedef logic [3:0] condCode_t;

    // Status flags as produced by fpuDiv, one bit per exception class.
    typedef logic [4:0] opStatusFlag_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } divIssueState_t;

endpackage

// File: rtl/fpu_operand_fifo.sv
// Operand-pair FIFO: DEPTH entries (power of two), pointers wrap naturally.
// The head pair stays put until pop_i, so it can feed the divider directly.
module fpu_operand_fifo
    import fpu_div_issue_pkg::*;
#(
    parameter type         FP_T  = fp16_t,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  FP_T                     a_i,
    input  FP_T                     b_i,
    output FP_T                     head_a_o,
    output FP_T                     head_b_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    FP_T             mem_a_q [DEPTH];
    FP_T             mem_b_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok;
    logic            pop_ok;

    assign full_o   = (count_q == CntW'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign head_a_o = mem_a_q[rd_ptr_q];
    assign head_b_o = mem_b_q[rd_ptr_q];
    assign push_ok  = push_i && !full_o;
    assign pop_ok   = pop_i && !empty_o;

    // Pointer and occupancy next state; simultaneous push/pop keeps the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: ;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates their use.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_a_q[wr_ptr_q] <= a_i;
            mem_b_q[wr_ptr_q] <= b_i;
        end
    end

endmodule

// File: rtl/fpu_div_issue.sv
// Operand queue + start/done handshake adapter around an external fpuDiv.
// Optional feature macro: FPU_DIV_STICKY_FLAGS_EN adds stickyClr/stickyFlags,
// an accumulating OR of every captured status flag set.
module fpu_div_issue
    import fpu_div_issue_pkg::*;
#(
    parameter type         FP_T  = fp16_t,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inValid,
    output logic                   inReady,
    input  FP_T                    inA,
    input  FP_T                    inB,
    output logic                   divStart,
    output FP_T                    divIn1,
    output FP_T                    divIn2,
    input  logic                   divDone,
    input  FP_T                    divOut,
    input  condCode_t              divCond,
    input  opStatusFlag_t          divFlags,
    output logic                   outValid,
    input  logic                   outReady,
    output FP_T                    outRes,
    output condCode_t              outCond,
    output opStatusFlag_t          outFlags,
`ifdef FPU_DIV_STICKY_FLAGS_EN
    input  logic                   stickyClr,
    output opStatusFlag_t          stickyFlags,
`endif
    output logic [$clog2(DEPTH):0] occupancy
);

    divIssueState_t state_q, state_d;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           capture;
    logic           slot_free;

    logic           out_valid_q, out_valid_d;
    FP_T            out_res_q, out_res_d;
    condCode_t      out_cond_q, out_cond_d;
    opStatusFlag_t  out_flags_q, out_flags_d;

    assign inReady   = !fifo_full;
    assign push      = inValid && inReady;
    // divDone only counts while waiting; stale pulses after a reset are dropped.
    assign capture   = (state_q == WAIT) && divDone;
    assign slot_free = !out_valid_q || outReady;

    fpu_operand_fifo #(
        .FP_T  (FP_T),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clock),
        .rst_ni   (reset),
        .push_i   (push),
        .pop_i    (capture),
        .a_i      (inA),
        .b_i      (inB),
        .head_a_o (divIn1),
        .head_b_o (divIn2),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (occupancy)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: issue only when the result slot can take the answer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty && slot_free) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (divDone) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: one-cycle start pulse.
    always_comb begin
        divStart = (state_q == ISSUE);
    end

    // Result slot next state; a capture overrides a same-cycle acceptance.
    always_comb begin
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_cond_d  = out_cond_q;
        out_flags_d = out_flags_q;
        if (capture) begin
            out_valid_d = 1'b1;
            out_res_d   = divOut;
            out_cond_d  = divCond;
            out_flags_d = divFlags;
        end else if (out_valid_q && outReady) begin
            out_valid_d = 1'b0;
        end
    end

    // Result slot registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_cond_q  <= '0;
            out_flags_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_cond_q  <= out_cond_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign outValid = out_valid_q;
    assign outRes   = out_res_q;
    assign outCond  = out_cond_q;
    assign outFlags = out_flags_q;

`ifdef FPU_DIV_STICKY_FLAGS_EN
    opStatusFlag_t sticky_q, sticky_d;

    // Clear wins over accumulation; a coincident capture seeds the fresh value.
    always_comb begin
        sticky_d = sticky_q;
        if (stickyClr)    sticky_d = capture ? divFlags : '0;
        else if (capture) sticky_d = sticky_q | divFlags;
    end

    // Sticky flag register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sticky_q <= '0;
        else        sticky_q <= sticky_d;
    end

    assign stickyFlags = sticky_q;
`endif

endmodule

// File: tb/tb_fpu_div_issue.sv
// Directed bench for fpu_div_issue with a fixed-latency divider model.
module tb_fpu_div_issue;
    import fpu_div_issue_pkg::*;

    localparam int LAT = 5;
    localparam int NV  = 8;

    typedef struct {
        fp16_t         a;
        fp16_t         b;
        fp16_t         q;
        condCode_t     cond;
        opStatusFlag_t flags;
    } vec_t;

    vec_t vec [NV];

    logic          clock;
    logic          reset;
    logic          inValid;
    logic          inReady;
    fp16_t         inA;
    fp16_t         inB;
    logic          divStart;
    fp16_t         divIn1;
    fp16_t         divIn2;
    logic          divDone;
    fp16_t         divOut;
    condCode_t     divCond;
    opStatusFlag_t divFlags;
    logic          outValid;
    logic          outReady;
    fp16_t         outRes;
    condCode_t     outCond;
    opStatusFlag_t outFlags;
    logic [2:0]    occupancy;
`ifdef FPU_DIV_STICKY_FLAGS_EN
    logic          stickyClr;
    opStatusFlag_t stickyFlags;
`endif

    int n_checks = 0;
    int n_err    = 0;
    // Divider-model observations.
    int n_starts = 0;
    int n_unknown = 0;
    int n_pulse_bad = 0;
    int n_unstable = 0;
    int n_lat_bad = 0;
    logic chk_lat = 1'b0;

    fpu_div_issue #(
        .FP_T  (fp16_t),
        .DEPTH (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .inValid     (inValid),
        .inReady     (inReady),
        .inA         (inA),
        .inB         (inB),
        .divStart    (divStart),
        .divIn1      (divIn1),
        .divIn2      (divIn2),
        .divDone     (divDone),
        .divOut      (divOut),
        .divCond     (divCond),
        .divFlags    (divFlags),
        .outValid    (outValid),
        .outReady    (outReady),
        .outRes      (outRes),
        .outCond     (outCond),
        .outFlags    (outFlags),
`ifdef FPU_DIV_STICKY_FLAGS_EN
        .stickyClr   (stickyClr),
        .stickyFlags (stickyFlags),
`endif
        .occupancy   (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic int find_vec(input fp16_t a, input fp16_t b);
        for (int i = 0; i < NV; i++) begin
            if (vec[i].a == a && vec[i].b == b) return i;
        end
        return -1;
    endfunction

    // Fixed-latency divider: answers from the vector table keyed by operands.
    initial begin
        int    idx;
        fp16_t cur_a;
        fp16_t cur_b;
        divDone  = 1'b0;
        divOut   = '0;
        divCond  = '0;
        divFlags = '0;
        forever begin
            @(negedge clock);
            if (divStart === 1'b1 && reset === 1'b1) begin
                cur_a = divIn1;
                cur_b = divIn2;
                n_starts++;
                idx = find_vec(cur_a, cur_b);
                if (idx < 0) n_unknown++;
                @(posedge clock);
                for (int i = 0; i < LAT - 1; i++) begin
                    @(negedge clock);
                    if (chk_lat) begin
                        if (i == 0 && divStart !== 1'b0) n_pulse_bad++;
                        if (divIn1 !== cur_a || divIn2 !== cur_b) n_unstable++;
                    end
                    @(posedge clock);
                end
                #1;
                divDone  = 1'b1;
                divOut   = (idx >= 0) ? vec[idx].q : 16'hdead;
                divCond  = (idx >= 0) ? vec[idx].cond : 4'hf;
                divFlags = (idx >= 0) ? vec[idx].flags : 5'h1f;
                @(negedge clock);
                if (chk_lat && (outValid !== 1'b0 || divIn1 !== cur_a)) n_lat_bad++;
                @(posedge clock);
                #1;
                divDone  = 1'b0;
                divOut   = '0;
                divCond  = '0;
                divFlags = '0;
                @(negedge clock);
                if (chk_lat && outValid !== 1'b1) n_lat_bad++;
            end
        end
    end

    task automatic push(input int idx);
        int n = 0;
        while (inReady !== 1'b1 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (inReady !== 1'b1) begin
            report_timeout("push_ready");
        end else begin
            inValid = 1'b1;
            inA     = vec[idx].a;
            inB     = vec[idx].b;
            @(posedge clock);
            #1;
            inValid = 1'b0;
        end
    endtask

    // Wait for a result, compare with vec[idx], optionally hold it, then accept.
    task automatic get_result(input int idx, input int hold);
        int n  = 0;
        int s0;
        @(negedge clock);
        while (outValid !== 1'b1 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (outValid !== 1'b1) begin
            report_timeout($sformatf("result_%0d", idx));
        end else begin
            check($sformatf("res_%0d", idx), outRes, vec[idx].q);
            check($sformatf("cond_%0d", idx), outCond, vec[idx].cond);
            check($sformatf("flags_%0d", idx), outFlags, vec[idx].flags);
            if (hold > 0) begin
                s0 = n_starts;
                repeat (hold) @(negedge clock);
                check("held_valid", outValid, 1'b1);
                check("held_res", outRes, vec[idx].q);
                check("no_issue_while_slot_busy", n_starts, s0);
            end
            @(posedge clock);
            #1;
            outReady = 1'b1;
            @(posedge clock);
            #1;
            outReady = 1'b0;
        end
    endtask

    initial begin
        int    s0;
        int    bad;
        int    n;
        fp16_t got_q[$];

        vec[0] = '{16'h3C00, 16'h4000, 16'h3800, 4'h1, 5'b00001};
        vec[1] = '{16'h4400, 16'h4000, 16'h4000, 4'h2, 5'b00100};
        vec[2] = '{16'h4200, 16'h3C00, 16'h4200, 4'h3, 5'b10000};
        vec[3] = '{16'h4800, 16'h4400, 16'h4000, 4'h4, 5'b00000};
        vec[4] = '{16'h3C00, 16'h4400, 16'h3400, 4'h5, 5'b00010};
        vec[5] = '{16'h4500, 16'h3C00, 16'h4500, 4'h6, 5'b01000};
        vec[6] = '{16'h4A00, 16'h4200, 16'h4400, 4'h7, 5'b00001};
        vec[7] = '{16'h4C00, 16'h4800, 16'h4000, 4'h8, 5'b00011};

        reset    = 1'b0;
        inValid  = 1'b0;
        inA      = '0;
        inB      = '0;
        outReady = 1'b0;
`ifdef FPU_DIV_STICKY_FLAGS_EN
        stickyClr = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);

        // Reset state.
        check("rst_occupancy", occupancy, 0);
        check("rst_inReady", inReady, 1'b1);
        check("rst_divStart", divStart, 1'b0);
        check("rst_outValid", outValid, 1'b0);
        check("rst_outRes", outRes, 16'h0000);
        check("rst_outCond", outCond, 4'h0);
        check("rst_outFlags", outFlags, 5'h00);
`ifdef FPU_DIV_STICKY_FLAGS_EN
        check("rst_sticky", stickyFlags, 5'h00);
`endif

        // Single operation with issue and capture latency.
        chk_lat = 1'b1;
        push(0);
        @(negedge clock);
        check("start_not_early", divStart, 1'b0);
        @(negedge clock);
        check("start_latency", divStart, 1'b1);
        get_result(0, 0);
        chk_lat = 1'b0;
        check("single_occ_empty", occupancy, 0);
        check("single_start_count", n_starts, 1);
        check("start_pulse_one_cycle", n_pulse_bad, 0);
        check("operands_stable", n_unstable, 0);
        check("done_to_valid_latency", n_lat_bad, 0);

        // Fill the FIFO while the consumer stalls.
        push(1);
        push(2);
        push(3);
        push(4);
        @(negedge clock);
        check("occ_full", occupancy, 4);
        check("inReady_full", inReady, 1'b0);
        @(posedge clock);
        #1;
        inValid = 1'b1;
        inA     = 16'h5555;
        inB     = 16'h1111;
        @(posedge clock);
        @(posedge clock);
        #1;
        inValid = 1'b0;
        @(negedge clock);
        check("occ_reject_when_full", occupancy, 4);
        get_result(1, 10);
        get_result(2, 0);
        get_result(3, 0);
        get_result(4, 0);

        // Table-driven batch that wraps the pointers a second time.
        for (int i = 5; i < NV; i++) push(i);
        for (int i = 5; i < NV; i++) get_result(i, 0);
        check("wrap_occ_empty", occupancy, 0);
        check("wrap_start_count", n_starts, 8);
        check("no_unknown_operands", n_unknown, 0);

        // Consumer always ready: every capture must be seen exactly once.
        outReady = 1'b1;
        push(2);
        push(5);
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (outValid === 1'b1 && outReady === 1'b1) got_q.push_back(outRes);
        end
        outReady = 1'b0;
        check("ready_capture_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("ready_capture_first", got_q[0], vec[2].q);
            check("ready_capture_second", got_q[1], vec[5].q);
        end

`ifdef FPU_DIV_STICKY_FLAGS_EN
        // Sticky flag accumulation and clear.
        @(posedge clock);
        #1;
        stickyClr = 1'b1;
        @(posedge clock);
        #1;
        stickyClr = 1'b0;
        @(negedge clock);
        check("sticky_clear", stickyFlags, 5'b00000);
        push(0);
        get_result(0, 0);
        push(1);
        get_result(1, 0);
        check("sticky_accumulate", stickyFlags, 5'b00101);
        push(2);
        n = 0;
        @(negedge clock);
        while (divDone !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (divDone !== 1'b1) begin
            report_timeout("sticky_done");
        end else begin
            stickyClr = 1'b1;
            @(posedge clock);
            #1;
            stickyClr = 1'b0;
        end
        get_result(2, 0);
        check("sticky_clear_with_capture", stickyFlags, 5'b10000);
`endif

        // Reset while the divider is busy; its late done must be ignored.
        s0 = n_starts;
        push(3);
        n = 0;
        @(negedge clock);
        while (divStart !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (divStart !== 1'b1) report_timeout("reset_test_start");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("async_rst_occ", occupancy, 0);
        check("async_rst_valid", outValid, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clock);
            if (outValid !== 1'b0) bad++;
        end
        check("no_capture_after_reset", bad, 0);
        check("reset_occ_empty", occupancy, 0);
        check("no_reissue_after_reset", n_starts, s0 + 1);
        check("reset_res_zero", outRes, 16'h0000);
`ifdef FPU_DIV_STICKY_FLAGS_EN
        check("reset_sticky_zero", stickyFlags, 5'b00000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
